// File: rtl/alu_arb_seq_if.sv
// Request/response bundle between two requesters, one consumer and the
// arbitrated sequential ALU.
interface alu_arb_seq_if;
  localparam int unsigned DW  = 4;
  localparam int unsigned OPW = 3;

  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;

  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;

  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [DW-1:0]  rsp_result;
  logic [DW-1:0]  rsp_sm;
  logic           rsp_ovf;
  logic           rsp_flag;
  logic           busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_sm, rsp_ovf, rsp_flag, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_sm, rsp_ovf, rsp_flag, busy
  );
endinterface

// File: rtl/alu_arb_seq.sv
// Two-requester arbitrated 4-bit ALU: accept one operation, execute it,
// then hold the response until the consumer takes it.
module alu_arb_seq #(
  parameter bit RR_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  alu_arb_seq_if.slave bus
);
  localparam int unsigned DW  = 4;
  localparam int unsigned OPW = 3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q;
  logic           last_grant_q;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  a_q;
  logic [DW-1:0]  b_q;
  logic           id_q;
  logic           rsp_valid_q;
  logic           rsp_id_q;
  logic [DW-1:0]  rsp_result_q;
  logic [DW-1:0]  rsp_sm_q;
  logic           rsp_ovf_q;
  logic           rsp_flag_q;
  logic           busy_q;

  logic           grant_c;
  logic           grant_id_c;
  logic [OPW-1:0] sel_op_c;
  logic [DW-1:0]  sel_a_c;
  logic [DW-1:0]  sel_b_c;
  logic [DW-1:0]  alu_res_c;
  logic [DW-1:0]  alu_mag_c;
  logic [DW-1:0]  alu_sm_c;
  logic           alu_ovf_c;
  logic           alu_flag_c;

  // Arbitration: only offered in IDLE; on contention RR picks the requester not served last
  always_comb begin
    grant_id_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id_c = RR_EN ? ~last_grant_q : 1'b0;
    end else if (bus.req1_valid) begin
      grant_id_c = 1'b1;
    end
    grant_c  = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
    sel_op_c = grant_id_c ? bus.req1_op : bus.req0_op;
    sel_a_c  = grant_id_c ? bus.req1_a  : bus.req0_a;
    sel_b_c  = grant_id_c ? bus.req1_b  : bus.req0_b;
  end

  assign bus.req0_ready = grant_c && !grant_id_c;
  assign bus.req1_ready = grant_c &&  grant_id_c;

  // ALU on the latched operands
  always_comb begin
    alu_res_c  = '0;
    alu_ovf_c  = 1'b0;
    alu_flag_c = 1'b0;
    case (op_q)
      3'b000: begin
        alu_res_c = a_q + b_q;
        alu_ovf_c = (a_q[DW-1] == b_q[DW-1]) && (alu_res_c[DW-1] != a_q[DW-1]);
      end
      3'b001: begin
        alu_res_c = a_q - b_q;
        alu_ovf_c = (a_q[DW-1] != b_q[DW-1]) && (alu_res_c[DW-1] != a_q[DW-1]);
      end
      3'b010: alu_res_c = ~a_q;
      3'b011: alu_res_c = a_q & b_q;
      3'b100: alu_res_c = a_q | b_q;
      3'b101: alu_res_c = a_q ^ b_q;
      3'b110: begin
        alu_flag_c = $signed(a_q) < $signed(b_q);
        alu_res_c  = {3'b000, alu_flag_c};
      end
      3'b111: begin
        alu_flag_c = (a_q == b_q);
        alu_res_c  = {3'b000, alu_flag_c};
      end
    endcase
    if (op_q[2:1] != 2'b11) alu_flag_c = alu_res_c[DW-1];
    // -8 negates to itself, so its low bits are 000 and the sign-magnitude code is 1000
    alu_mag_c = DW'(0) - alu_res_c;
    alu_sm_c  = alu_res_c[DW-1] ? {1'b1, alu_mag_c[DW-2:0]} : alu_res_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_sm_q     <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_c) begin
            op_q         <= sel_op_c;
            a_q          <= sel_a_c;
            b_q          <= sel_b_c;
            id_q         <= grant_id_c;
            last_grant_q <= grant_id_c;
            busy_q       <= 1'b1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid_q  <= 1'b1;
          rsp_id_q     <= id_q;
          rsp_result_q <= alu_res_c;
          rsp_sm_q     <= alu_sm_c;
          rsp_ovf_q    <= alu_ovf_c;
          rsp_flag_q   <= alu_flag_c;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_sm     = rsp_sm_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.rsp_flag   = rsp_flag_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_alu_arb_seq.sv
// Scoreboard bench for alu_arb_seq: a round-robin and a fixed-priority
// instance share clock and reset.
module tb_alu_arb_seq;
  typedef struct packed {
    logic       id;
    logic [3:0] res;
    logic [3:0] sm;
    logic       ovf;
    logic       flag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arb_seq_if ifc ();
  alu_arb_seq_if ifc_fp ();

  alu_arb_seq #(.RR_EN(1'b1)) dut    (.clk(clk), .rst(rst), .bus(ifc.slave));
  alu_arb_seq #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(ifc_fp.slave));

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  // Reference model built on integer arithmetic
  function automatic exp_t model(input logic id, input logic [2:0] op,
                                 input logic [3:0] a, input logic [3:0] b);
    int         sa, sb, t;
    logic [3:0] r;
    exp_t       e;
    sa = int'($signed(a));
    sb = int'($signed(b));
    e  = '0;
    r  = '0;
    e.id = id;
    case (op)
      3'd0: begin t = sa + sb; e.ovf = (t > 7) || (t < -8); r = 4'(t); end
      3'd1: begin t = sa - sb; e.ovf = (t > 7) || (t < -8); r = 4'(t); end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = (sa < sb) ? 4'd1 : 4'd0;
      3'd7: r = (a == b) ? 4'd1 : 4'd0;
    endcase
    e.res  = r;
    e.flag = (op >= 3'd6) ? r[0] : r[3];
    t      = int'($signed(r));
    e.sm   = (t < 0) ? 4'(8 + ((-t) % 8)) : r;
    return e;
  endfunction

  function automatic exp_t obs();
    return {ifc.rsp_id, ifc.rsp_result, ifc.rsp_sm, ifc.rsp_ovf, ifc.rsp_flag};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifc.req0_valid = 0; ifc.req0_op = '0; ifc.req0_a = '0; ifc.req0_b = '0;
    ifc.req1_valid = 0; ifc.req1_op = '0; ifc.req1_a = '0; ifc.req1_b = '0;
    ifc.rsp_ready  = 0;
    ifc_fp.req0_valid = 0; ifc_fp.req0_op = '0; ifc_fp.req0_a = '0; ifc_fp.req0_b = '0;
    ifc_fp.req1_valid = 0; ifc_fp.req1_op = '0; ifc_fp.req1_a = '0; ifc_fp.req1_b = '0;
    ifc_fp.rsp_ready  = 0;
  endtask

  // Present one request on one port; push the expected response when it is accepted
  task automatic issue(input logic port, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, output logic ok);
    ok = 1'b0;
    if (port) begin
      ifc.req1_valid = 1; ifc.req1_op = op; ifc.req1_a = a; ifc.req1_b = b;
    end else begin
      ifc.req0_valid = 1; ifc.req0_op = op; ifc.req0_a = a; ifc.req0_b = b;
    end
    #1;
    for (int c = 0; c < 8; c++) begin
      if ((port ? ifc.req1_ready : ifc.req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      sb_q.push_back(model(port, op, a, b));
      step();
    end
    ifc.req0_valid = 0;
    ifc.req1_valid = 0;
  endtask

  task automatic wait_rsp();
    for (int c = 0; c < 10 && ifc.rsp_valid !== 1'b1; c++) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs() !== exp_t'(0)) begin
      n_bad++; $display("FAIL reset_rsp: got %h expected %h", obs(), exp_t'(0));
    end
    n_cmp++;
    if ({ifc.rsp_valid, ifc.busy, ifc.req0_ready, ifc.req1_ready} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got valid/busy/rdy0/rdy1 %b%b%b%b expected 0000",
               ifc.rsp_valid, ifc.busy, ifc.req0_ready, ifc.req1_ready);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic ok;
    exp_t e, got;
    issue(1'b0, 3'b000, 4'b1110, 4'b0001, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_accept: got %b expected 1", ok); end
    n_cmp++;
    if ({ifc.rsp_valid, ifc.busy} !== 2'b01) begin
      n_bad++; $display("FAIL basic_exec: got valid/busy %b%b expected 01", ifc.rsp_valid, ifc.busy);
    end
    step();
    n_cmp++;
    if (ifc.rsp_valid !== 1'b1) begin
      n_bad++; $display("FAIL basic_latency: got rsp_valid %b expected 1", ifc.rsp_valid);
    end
    got = obs();
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL basic_rsp: got %h expected %h", got, e); end
    n_cmp++;
    if (got !== exp_t'({1'b0, 4'b1111, 4'b1001, 1'b0, 1'b1})) begin
      n_bad++; $display("FAIL basic_const: got %h expected %h", got,
                        exp_t'({1'b0, 4'b1111, 4'b1001, 1'b0, 1'b1}));
    end
    ifc.rsp_ready = 1;
    step();
    ifc.rsp_ready = 0;
    n_cmp++;
    if ({ifc.rsp_valid, ifc.busy} !== 2'b00) begin
      n_bad++; $display("FAIL basic_done: got valid/busy %b%b expected 00", ifc.rsp_valid, ifc.busy);
    end
  endtask

  task automatic test_ops();
    logic [2:0] ops[13] = '{3'd0, 3'd1, 3'd6, 3'd7, 3'd1, 3'd0, 3'd2,
                            3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
    logic [3:0] as[13]  = '{4'h7, 4'h8, 4'hF, 4'h5, 4'h3, 4'h8, 4'h5,
                            4'hC, 4'hC, 4'hF, 4'h1, 4'h4, 4'h8};
    logic [3:0] bs[13]  = '{4'h1, 4'h1, 4'h1, 4'h5, 4'h5, 4'h8, 4'h0,
                            4'hA, 4'h3, 4'h5, 4'hF, 4'h5, 4'h8};
    logic ok;
    exp_t e, got;
    for (int i = 0; i < 25; i++) begin
      if (i < 13) issue(1'(i % 2), ops[i], as[i], bs[i], ok);
      else issue(1'($urandom_range(1)), 3'($urandom_range(7)), 4'($urandom_range(15)),
                 4'($urandom_range(15)), ok);
      wait_rsp();
      got = obs();
      e = (ok && sb_q.size() > 0) ? sb_q.pop_front() : '1;
      n_cmp++;
      if (ifc.rsp_valid !== 1'b1 || got !== e) begin
        n_bad++;
        $display("FAIL ops_%0d: got valid %b rsp %h expected valid 1 rsp %h",
                 i, ifc.rsp_valid, got, e);
      end
      ifc.rsp_ready = 1;
      step();
      ifc.rsp_ready = 0;
    end
  endtask

  task automatic test_back_to_back();
    logic exp_g = 1'b0;
    int   last_acc = -1;
    exp_t e, got;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    ifc.req0_op = 3'd0; ifc.req0_a = 4'h3; ifc.req0_b = 4'h2;
    ifc.req1_op = 3'd1; ifc.req1_a = 4'h2; ifc.req1_b = 4'h5;
    ifc_fp.req0_op = 3'd4; ifc_fp.req1_op = 3'd5;
    ifc.req0_valid = 1; ifc.req1_valid = 1; ifc.rsp_ready = 1;
    ifc_fp.req0_valid = 1; ifc_fp.req1_valid = 1; ifc_fp.rsp_ready = 1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      #1;
      if (ifc.rsp_valid === 1'b1) begin
        got = obs();
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL rr_rsp_%0d: got %h expected %h", cyc, got, e); end
      end
      if (ifc.req0_ready === 1'b1 || ifc.req1_ready === 1'b1) begin
        n_cmp++;
        if (ifc.req1_ready !== exp_g || (last_acc >= 0 && cyc - last_acc != 3)) begin
          n_bad++;
          $display("FAIL rr_grant_%0d: got grant %b gap %0d expected grant %b gap 3",
                   cyc, ifc.req1_ready, cyc - last_acc, exp_g);
        end
        sb_q.push_back(ifc.req1_ready ? model(1'b1, 3'd1, 4'h2, 4'h5)
                                      : model(1'b0, 3'd0, 4'h3, 4'h2));
        exp_g = ~exp_g;
        last_acc = cyc;
      end
      if (ifc_fp.req0_ready === 1'b1 || ifc_fp.req1_ready === 1'b1) begin
        n_cmp++;
        if ({ifc_fp.req0_ready, ifc_fp.req1_ready} !== 2'b10) begin
          n_bad++; $display("FAIL fp_grant_%0d: got rdy0/rdy1 %b%b expected 10",
                            cyc, ifc_fp.req0_ready, ifc_fp.req1_ready);
        end
      end
      if (ifc_fp.rsp_valid === 1'b1) begin
        n_cmp++;
        if (ifc_fp.rsp_id !== 1'b0) begin
          n_bad++; $display("FAIL fp_rsp_id_%0d: got %b expected 0", cyc, ifc_fp.rsp_id);
        end
      end
      step();
    end
    idle_inputs();
    ifc.rsp_ready = 1; ifc_fp.rsp_ready = 1;
    for (int c = 0; c < 4; c++) begin
      if (ifc.rsp_valid === 1'b1) begin
        got = obs();
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL rr_drain: got %h expected %h", got, e); end
      end
      step();
    end
    ifc.rsp_ready = 0; ifc_fp.rsp_ready = 0;
  endtask

  task automatic test_backpressure();
    logic ok;
    exp_t e, snap;
    issue(1'b1, 3'd5, 4'hA, 4'h3, ok);
    wait_rsp();
    snap = obs();
    e = (ok && sb_q.size() > 0) ? sb_q.pop_front() : '1;
    n_cmp++;
    if (ifc.rsp_valid !== 1'b1 || snap !== e) begin
      n_bad++; $display("FAIL bp_rsp: got valid %b rsp %h expected valid 1 rsp %h",
                        ifc.rsp_valid, snap, e);
    end
    ifc.req0_valid = 1; ifc.req1_valid = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if ({obs(), ifc.rsp_valid, ifc.req0_ready, ifc.req1_ready, ifc.busy} !== {snap, 4'b1001}) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: got rsp %h v/r0/r1/busy %b%b%b%b expected rsp %h 1001", k,
                 obs(), ifc.rsp_valid, ifc.req0_ready, ifc.req1_ready, ifc.busy, snap);
      end
      step();
    end
    ifc.req0_valid = 0; ifc.req1_valid = 0; ifc.rsp_ready = 1;
    step();
    ifc.rsp_ready = 0;
    ifc.req0_valid = 1;
    #1;
    n_cmp++;
    if ({ifc.rsp_valid, ifc.busy, ifc.req0_ready} !== 3'b001) begin
      n_bad++; $display("FAIL bp_release: got valid/busy/rdy0 %b%b%b expected 001",
                        ifc.rsp_valid, ifc.busy, ifc.req0_ready);
    end
    ifc.req0_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic ok;
    logic seen;
    exp_t e, got;
    issue(1'b0, 3'd1, 4'h1, 4'h6, ok);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== exp_t'(0) || {ifc.rsp_valid, ifc.busy} !== 2'b00) begin
      n_bad++; $display("FAIL mid_reset: got rsp %h valid/busy %b%b expected 0 00",
                        obs(), ifc.rsp_valid, ifc.busy);
    end
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (ifc.rsp_valid !== 1'b0) seen = 1'b1;
      step();
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_no_rsp: got stray rsp_valid %b expected 0", seen); end
    ifc.req0_valid = 1; ifc.req0_op = 3'd0; ifc.req0_a = 4'h6; ifc.req0_b = 4'h4;
    ifc.req1_valid = 1; ifc.req1_op = 3'd3; ifc.req1_a = 4'hF; ifc.req1_b = 4'h9;
    #1;
    n_cmp++;
    if ({ifc.req0_ready, ifc.req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL mid_pref0: got rdy0/rdy1 %b%b expected 10", ifc.req0_ready, ifc.req1_ready);
    end
    if (ifc.req0_ready === 1'b1) sb_q.push_back(model(1'b0, 3'd0, 4'h6, 4'h4));
    else if (ifc.req1_ready === 1'b1) sb_q.push_back(model(1'b1, 3'd3, 4'hF, 4'h9));
    step();
    ifc.req0_valid = 0; ifc.req1_valid = 0;
    wait_rsp();
    got = obs();
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    n_cmp++;
    if (ifc.rsp_valid !== 1'b1 || got !== e) begin
      n_bad++; $display("FAIL mid_rsp: got valid %b rsp %h expected valid 1 rsp %h",
                        ifc.rsp_valid, got, e);
    end
    ifc.rsp_ready = 1;
    step();
    ifc.rsp_ready = 0;
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_basic();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++; $display("FAIL sb_empty: got %0d leftover expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
